leve_ifetch: RTL and testbench
==============================

Name: leve_ifetch

Overview:
Instruction-fetch stage directly downstream of the PC generator. Takes the current PC under a valid/ready handshake and issues in-order requests to the instruction memory port. Pairs each returned 32-bit instruction word with its PC in a small instruction buffer feeding decode. On redirect (FLUSH) it empties all buffers and silently discards memory responses still in flight.

Parameters:
XLEN, 64, address/PC width
ILEN, 32, instruction word width
IBUF_DEPTH, 4, instruction buffer entries (power of 2, >=2)
MAX_OUT, 2, max outstanding memory requests (power of 2, <=IBUF_DEPTH)

Ports:
CLK  in  1  clock
RST  in  1  reset; one clock; reset is asynchronous and active-high
PC  in  XLEN  fetch address from PC generator
PC_VALID  in  1  PC holds a fetch address
PC_READY  out  1  PC accepted this cycle (PC generator advances on it)
FLUSH  in  1  redirect: discard all fetched/in-flight work
IMEM_REQ  out  1  memory request valid
IMEM_ADDR  out  XLEN  request address (equals PC)
IMEM_GNT  in  1  request accepted
IMEM_RVALID  in  1  response valid (in order, >=1 cycle after its grant)
IMEM_RDATA  in  ILEN  response instruction word
INST_VALID  out  1  buffer head valid
INST  out  ILEN  head instruction
INST_PC  out  XLEN  head PC
INST_READY  in  1  decode consumes head

Behaviour:
- Reset (async, RST=1): buffers empty, counters 0; INST_VALID=0, IMEM_REQ=0, PC_READY=0, INST/INST_PC=0. Reset mid-transaction drops everything; responses to pre-reset grants are not tracked (memory is reset together).
- Counters: out_cnt = granted, not returned, not marked for drop; drop_cnt = in-flight responses to discard; ibuf_cnt = buffer occupancy.
- credit = (out_cnt < MAX_OUT) && (out_cnt + ibuf_cnt < IBUF_DEPTH). Pops in the same cycle do not count (no same-cycle credit return).
- IMEM_REQ = PC_VALID && credit && !FLUSH && !RST (combinational). IMEM_ADDR = PC.
- PC_READY = IMEM_REQ && IMEM_GNT. On this, push PC into pending queue (depth MAX_OUT); out_cnt++.
- IMEM_RVALID with drop_cnt>0: drop_cnt--, data discarded, pending queue untouched.
- IMEM_RVALID with drop_cnt==0: pop pending PC, push {PC, RDATA} into instruction buffer; out_cnt--. Instruction is visible on INST_VALID the next cycle (registered buffer, 1-cycle response-to-decode latency).
- Grant and response in the same cycle: both take effect; out_cnt unchanged.
- INST_VALID = ibuf_cnt != 0. INST/INST_PC show the head. Pop on INST_VALID && INST_READY. Push and pop in the same cycle are allowed at any occupancy. Overflow is impossible by the credit rule.
- FLUSH (highest priority):
  - instruction buffer and pending queue cleared; INST_VALID=0 next cycle.
  - no request issued in the flush cycle.
  - drop_cnt_next = drop_cnt + out_cnt - (IMEM_RVALID ? 1 : 0); out_cnt_next = 0.
  - any response arriving in the flush cycle is discarded.
  - INST_READY in the flush cycle is ignored.
- Back-to-back FLUSH cycles accumulate correctly under the same formula.
- Requests after a flush may issue while drop_cnt>0. Ordering guarantees the first drop_cnt responses belong to pre-flush requests.
- Assertions: no IMEM_RVALID when out_cnt+drop_cnt==0; pending queue never overflows.

Decomposition:
- leve_pkg holds XLEN, ILEN, and typedef fetch_ent_t {pc[XLEN], inst[ILEN]}.
- One generic sub-module, leve_fifo (parameters WIDTH, DEPTH; push/pop/flush; count/full/empty outputs). It is instantiated twice: pending-PC queue (WIDTH=XLEN, DEPTH=MAX_OUT) and instruction buffer (fetch_ent_t, DEPTH=IBUF_DEPTH).
- Counters and handshake logic live in leve_ifetch.

Test Plan:
1. Streaming: PC 0x8000_0000, +4 each PC_READY; GNT=1; RVALID 1 cycle after grant; INST_READY=1 -> INST_PC 0x8000_0000, 0x8000_0004, ... one per cycle, INST matches memory model, no gaps after warm-up.
2. Backpressure: INST_READY=0 -> exactly IBUF_DEPTH=4 entries accepted in total (including in-flight), then IMEM_REQ=0. Release -> order preserved, no loss or duplication.
3. Flush with 2 in flight: grants for 0x8000_0010 and 0x8000_0014, FLUSH before responses, then PC=0x8000_1000 -> both stale responses dropped; first INST_PC=0x8000_1000.
4. Flush coincident with a response: out_cnt=2, RVALID and FLUSH same cycle -> drop_cnt=1; next response dropped, following one delivered.
5. Memory stalls: GNT random 30%, response latency 1-5 cycles, INST_READY random -> scoreboard match; out_cnt never exceeds MAX_OUT=2.
6. Async reset asserted mid-burst (between clock edges) -> INST_VALID, IMEM_REQ, PC_READY low immediately; after release, fetch restarts cleanly from the new PC.

Source files
------------

// File: rtl/leve_pkg.sv
// Shared widths and payload types for the leve instruction-fetch stage.
package leve_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    // One decoded-ready fetch entry: instruction word paired with its PC.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_ent_t;

endpackage

// File: rtl/leve_ifetch_if.sv
// Fetch-stage bus: PC handshake, instruction-memory port and decode handshake.
interface leve_ifetch_if;
    import leve_pkg::*;

    logic [XLEN-1:0] PC;
    logic            PC_VALID;
    logic            PC_READY;
    logic            FLUSH;
    logic            IMEM_REQ;
    logic [XLEN-1:0] IMEM_ADDR;
    logic            IMEM_GNT;
    logic            IMEM_RVALID;
    logic [ILEN-1:0] IMEM_RDATA;
    logic            INST_VALID;
    logic [ILEN-1:0] INST;
    logic [XLEN-1:0] INST_PC;
    logic            INST_READY;

    // Fetch stage side.
    modport slave (
        input  PC, PC_VALID, FLUSH, IMEM_GNT, IMEM_RVALID, IMEM_RDATA, INST_READY,
        output PC_READY, IMEM_REQ, IMEM_ADDR, INST_VALID, INST, INST_PC
    );

    // Environment side (PC generator, memory, decode).
    modport master (
        output PC, PC_VALID, FLUSH, IMEM_GNT, IMEM_RVALID, IMEM_RDATA, INST_READY,
        input  PC_READY, IMEM_REQ, IMEM_ADDR, INST_VALID, INST, INST_PC
    );

endinterface

// File: rtl/leve_fifo.sv
// Generic synchronous FIFO with flush; push with pop is accepted even when full.
module leve_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign empty    = (cnt == '0);
    assign full     = (cnt == CNT_W'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];
    assign count    = cnt;

    // Pointers and occupancy; flush empties the queue.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage; cleared on reset so the head reads as zero while empty.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/leve_ifetch.sv
// Instruction fetch: issues in-order memory requests under a credit limit and
// pairs each returned word with its PC in a small buffer feeding decode.
module leve_ifetch
    import leve_pkg::*;
#(
    parameter int unsigned IBUF_DEPTH = 4,
    parameter int unsigned MAX_OUT    = 2
) (
    input  logic          CLK,
    input  logic          RST,
    leve_ifetch_if.slave  bus
);

    localparam int unsigned OUT_W  = $clog2(MAX_OUT + 1);
    localparam int unsigned IBC_W  = $clog2(IBUF_DEPTH + 1);
    localparam int unsigned SUM_W  = IBC_W + 1;
    localparam int unsigned DROP_W = 8;
    localparam int unsigned ENT_W  = $bits(fetch_ent_t);

    logic [OUT_W-1:0]  out_cnt;
    logic [OUT_W-1:0]  out_cnt_nxt;
    logic [DROP_W-1:0] drop_cnt;
    logic [DROP_W-1:0] drop_cnt_nxt;

    logic              credit;
    logic              imem_req;
    logic              grant;
    logic              rsp_keep;
    logic              rsp_drop;
    logic              inst_pop;

    logic [XLEN-1:0]   pend_head;
    logic [OUT_W-1:0]  pend_cnt;
    logic              pend_full;
    logic              pend_empty;

    fetch_ent_t        ibuf_in;
    fetch_ent_t        ibuf_head;
    logic [IBC_W-1:0]  ibuf_cnt;
    logic              ibuf_full;
    logic              ibuf_empty;

    // Credit counts only committed state; same-cycle pops do not free a slot.
    assign credit   = (out_cnt < OUT_W'(MAX_OUT)) &&
                      ((SUM_W'(out_cnt) + SUM_W'(ibuf_cnt)) < SUM_W'(IBUF_DEPTH));
    assign imem_req = bus.PC_VALID && credit && !bus.FLUSH && !RST;
    assign grant    = imem_req && bus.IMEM_GNT;
    assign rsp_drop = bus.IMEM_RVALID && (drop_cnt != '0);
    assign rsp_keep = bus.IMEM_RVALID && (drop_cnt == '0) && !bus.FLUSH;
    assign inst_pop = !ibuf_empty && bus.INST_READY && !bus.FLUSH;
    assign ibuf_in  = '{pc: pend_head, inst: bus.IMEM_RDATA};

    assign bus.IMEM_REQ   = imem_req;
    assign bus.IMEM_ADDR  = bus.PC;
    assign bus.PC_READY   = grant;
    assign bus.INST_VALID = !ibuf_empty;
    assign bus.INST       = ibuf_head.inst;
    assign bus.INST_PC    = ibuf_head.pc;

    // PCs of granted requests awaiting their response.
    leve_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUT)) u_pend (
        .CLK       (CLK),
        .RST       (RST),
        .flush     (bus.FLUSH),
        .push      (grant),
        .push_data (bus.PC),
        .pop       (rsp_keep),
        .pop_data  (pend_head),
        .count     (pend_cnt),
        .full      (pend_full),
        .empty     (pend_empty)
    );

    // Completed {PC, instruction} entries waiting for decode.
    leve_fifo #(.WIDTH(ENT_W), .DEPTH(IBUF_DEPTH)) u_ibuf (
        .CLK       (CLK),
        .RST       (RST),
        .flush     (bus.FLUSH),
        .push      (rsp_keep),
        .push_data (ibuf_in),
        .pop       (inst_pop),
        .pop_data  (ibuf_head),
        .count     (ibuf_cnt),
        .full      (ibuf_full),
        .empty     (ibuf_empty)
    );

    // Next outstanding/drop counts; a flush turns live requests into drops.
    always_comb begin
        out_cnt_nxt  = out_cnt;
        drop_cnt_nxt = drop_cnt;
        if (bus.FLUSH) begin
            out_cnt_nxt  = '0;
            drop_cnt_nxt = drop_cnt + DROP_W'(out_cnt) - DROP_W'(bus.IMEM_RVALID);
        end else begin
            out_cnt_nxt  = out_cnt + OUT_W'(grant) - OUT_W'(rsp_keep);
            drop_cnt_nxt = drop_cnt - DROP_W'(rsp_drop);
        end
    end

    // Counter registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            out_cnt  <= out_cnt_nxt;
            drop_cnt <= drop_cnt_nxt;
        end
    end

    // Protocol and internal-consistency checks.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            assert (!(bus.IMEM_RVALID && (out_cnt == '0) && (drop_cnt == '0)));
            assert (!(grant && pend_full && !rsp_keep));
            assert (!(rsp_keep && pend_empty));
            assert (!(rsp_keep && ibuf_full && !inst_pop));
            assert (pend_cnt == out_cnt);
        end
    end

endmodule

// File: tb/tb_leve_ifetch.sv
// Randomized bench for leve_ifetch with a queue-based reference model.
module tb_leve_ifetch;
    import leve_pkg::*;

    localparam int unsigned IBUF_DEPTH = 4;
    localparam int unsigned MAX_OUT    = 2;

    typedef struct {
        logic [XLEN-1:0] addr;
        int unsigned     due;
    } mreq_t;

    logic CLK;
    logic RST;

    leve_ifetch_if bus ();

    leve_ifetch #(.IBUF_DEPTH(IBUF_DEPTH), .MAX_OUT(MAX_OUT)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Reference model state
    mreq_t           mem_q[$];
    logic [XLEN-1:0] pend_q[$];
    fetch_ent_t      ibuf_q[$];
    int              drop_n;

    // Stimulus knobs
    int unsigned     gnt_pct, rdy_pct, pcv_pct, lat_min, lat_max;
    bit              flush_req;
    logic [XLEN-1:0] pc_q;
    int unsigned     cyc;

    int unsigned     n_cmp, n_bad;
    int unsigned     n_dut_grant, n_dut_pop;

    function automatic logic [ILEN-1:0] mem_word(input logic [XLEN-1:0] a);
        logic [XLEN-1:0] h;
        h = a * 64'h9E37_79B9_7F4A_7C15;
        return h[XLEN-1:XLEN-ILEN] ^ a[ILEN-1:0];
    endfunction

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mem_q.delete();
        pend_q.delete();
        ibuf_q.delete();
        drop_n = 0;
    endtask

    // One clock: drive at negedge, check, then advance the model to the next edge.
    task automatic tick();
        bit         exp_req;
        bit         rv;
        fetch_ent_t ent;
        @(negedge CLK);
        bus.FLUSH      = flush_req;
        flush_req      = 1'b0;
        bus.PC         = pc_q;
        bus.PC_VALID   = (($urandom % 100) < pcv_pct);
        bus.IMEM_GNT   = (($urandom % 100) < gnt_pct);
        bus.INST_READY = (($urandom % 100) < rdy_pct);
        rv = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
        bus.IMEM_RVALID = rv;
        bus.IMEM_RDATA  = rv ? mem_word(mem_q[0].addr) : ILEN'($urandom);
        #1;
        exp_req = bus.PC_VALID && !bus.FLUSH &&
                  (pend_q.size() < int'(MAX_OUT)) &&
                  (pend_q.size() + ibuf_q.size() < int'(IBUF_DEPTH));
        chk("imem_req", XLEN'(bus.IMEM_REQ), XLEN'(exp_req));
        chk("pc_ready", XLEN'(bus.PC_READY), XLEN'(exp_req && bus.IMEM_GNT));
        if (exp_req) chk("imem_addr", bus.IMEM_ADDR, pc_q);
        chk("inst_valid", XLEN'(bus.INST_VALID), XLEN'(ibuf_q.size() != 0));
        if (ibuf_q.size() != 0) begin
            chk("inst_pc", bus.INST_PC, ibuf_q[0].pc);
            chk("inst", XLEN'(bus.INST), XLEN'(ibuf_q[0].inst));
        end
        if (bus.PC_READY) n_dut_grant++;
        if (bus.INST_VALID && bus.INST_READY && !bus.FLUSH) n_dut_pop++;

        if (rv) void'(mem_q.pop_front());
        if (bus.FLUSH) begin
            drop_n = drop_n + pend_q.size() - (rv ? 1 : 0);
            pend_q.delete();
            ibuf_q.delete();
        end else begin
            if (ibuf_q.size() != 0 && bus.INST_READY) void'(ibuf_q.pop_front());
            if (rv) begin
                if (drop_n != 0) begin
                    drop_n--;
                end else begin
                    ent.pc   = pend_q.pop_front();
                    ent.inst = mem_word(ent.pc);
                    ibuf_q.push_back(ent);
                end
            end
            if (exp_req && bus.IMEM_GNT) begin
                pend_q.push_back(pc_q);
                mem_q.push_back('{addr: pc_q, due: cyc + $urandom_range(lat_max, lat_min)});
                pc_q = pc_q + XLEN'(4);
            end
        end
        cyc++;
    endtask

    task automatic run(input int unsigned n);
        for (int i = 0; i < int'(n); i++) tick();
    endtask

    task automatic set_knobs(input int unsigned pcv, input int unsigned gnt, input int unsigned rdy,
                             input int unsigned lmin, input int unsigned lmax);
        pcv_pct = pcv; gnt_pct = gnt; rdy_pct = rdy; lat_min = lmin; lat_max = lmax;
    endtask

    // Let everything in flight retire with no new fetches.
    task automatic drain();
        set_knobs(0, 100, 100, 1, 1);
        run(20);
    endtask

    // Tick until decode sees a valid head (bounded), then check its PC.
    task automatic wait_inst(input string tag, input logic [XLEN-1:0] exp_pc);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (bus.INST_VALID) found = 1'b1;
        end
        chk({tag, "_seen"}, XLEN'(found), XLEN'(1));
        if (found) chk(tag, bus.INST_PC, exp_pc);
    endtask

    task automatic zero_inputs();
        bus.PC = '0; bus.PC_VALID = 1'b0; bus.FLUSH = 1'b0; bus.IMEM_GNT = 1'b0;
        bus.IMEM_RVALID = 1'b0; bus.IMEM_RDATA = '0; bus.INST_READY = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0; flush_req = 1'b0;
        n_dut_grant = 0; n_dut_pop = 0;
        model_clear();
        set_knobs(0, 0, 0, 1, 1);
        RST = 1'b1;
        zero_inputs();
        pc_q = 64'h8000_0000;

        // Reset state
        @(negedge CLK);
        @(negedge CLK);
        #1;
        chk("rst_inst_valid", XLEN'(bus.INST_VALID), XLEN'(0));
        chk("rst_imem_req", XLEN'(bus.IMEM_REQ), XLEN'(0));
        chk("rst_pc_ready", XLEN'(bus.PC_READY), XLEN'(0));
        chk("rst_inst", XLEN'(bus.INST), XLEN'(0));
        chk("rst_inst_pc", bus.INST_PC, XLEN'(0));
        RST = 1'b0;

        // 1. Streaming: one instruction per cycle after warm-up
        pc_q = 64'h8000_0000;
        set_knobs(100, 100, 100, 1, 1);
        run(4);
        n_dut_pop = 0;
        run(36);
        chk("stream_throughput", XLEN'(n_dut_pop), XLEN'(36));

        // 2. Backpressure: exactly IBUF_DEPTH fetches accepted, then stall
        drain();
        set_knobs(100, 100, 0, 1, 1);
        n_dut_grant = 0;
        run(12);
        chk("bp_accepted", XLEN'(n_dut_grant), XLEN'(IBUF_DEPTH));
        chk("bp_req_low", XLEN'(bus.IMEM_REQ), XLEN'(0));
        set_knobs(0, 100, 100, 1, 1);
        n_dut_pop = 0;
        run(10);
        chk("bp_released", XLEN'(n_dut_pop), XLEN'(IBUF_DEPTH));

        // 3. Flush with two requests in flight
        drain();
        pc_q = 64'h8000_0010;
        set_knobs(100, 100, 100, 6, 6);
        n_dut_grant = 0;
        run(2);
        chk("flush_setup_grants", XLEN'(n_dut_grant), XLEN'(2));
        flush_req = 1'b1;
        tick();
        pc_q = 64'h8000_1000;
        wait_inst("flush_first_pc", 64'h8000_1000);

        // 4. Flush in the same cycle as a response
        drain();
        pc_q = 64'h8000_0100;
        set_knobs(100, 100, 100, 3, 3);
        run(3);
        flush_req = 1'b1;
        tick();
        pc_q = 64'h8000_2000;
        wait_inst("flushrsp_first_pc", 64'h8000_2000);

        // 5. Memory stalls, random latency, random decode stalls and flushes
        drain();
        pc_q = 64'h8000_4000;
        set_knobs(80, 30, 50, 1, 5);
        for (int i = 0; i < 2000; i++) begin
            flush_req = (($urandom % 100) < 2);
            tick();
        end

        // 6. Asynchronous reset mid-burst
        set_knobs(100, 100, 50, 1, 3);
        run(6);
        #2;
        RST = 1'b1;
        #1;
        chk("arst_inst_valid", XLEN'(bus.INST_VALID), XLEN'(0));
        chk("arst_imem_req", XLEN'(bus.IMEM_REQ), XLEN'(0));
        chk("arst_pc_ready", XLEN'(bus.PC_READY), XLEN'(0));
        model_clear();
        zero_inputs();
        @(negedge CLK);
        #1;
        chk("arst_inst_pc", bus.INST_PC, XLEN'(0));
        RST = 1'b0;
        pc_q = 64'h9000_0000;
        set_knobs(100, 100, 100, 1, 2);
        wait_inst("arst_first_pc", 64'h9000_0000);
        run(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
